// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises request lines and latches their rising edges as pending.
// It takes the lowest-index enabled request and pushes the PC with interrupt semantics. It turns
// reti into an interrupt-mode pop so that the interrupted instruction is re-fetched. There is no
// nesting: one handler is active at a time.
module irq_ctrl #(
    parameter int unsigned NIRQ       = 4,
    parameter logic [9:0]  VEC_BASE   = 10'h3C0,
    parameter int unsigned VEC_STRIDE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            ie_set,
    input  logic            ie_clr,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_in,
    input  logic            reti,
    input  logic            stack_full,
    output logic            push,
    output logic            pop,
    output logic            stack_int,
    output logic            pc_redirect,
    output logic [9:0]      vector,
    output logic            in_service,
    output logic [NIRQ-1:0] pending,
    output logic            reti_err
);

    localparam int unsigned IdW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StTake,
        StService,
        StReturn
    } state_e;

    state_e          state_q, state_d;

    logic [NIRQ-1:0] s1_q, s2_q, s3_q;
    logic [NIRQ-1:0] rise;
    logic [NIRQ-1:0] pending_q, pending_d;
    logic [NIRQ-1:0] take_clr;
    logic [NIRQ-1:0] mask_q, mask_d;
    logic [NIRQ-1:0] eligible;
    logic            gie_q, gie_d;
    logic            reti_err_q, reti_err_d;
    logic [IdW-1:0]  id_q, id_d, win_id;
    logic [9:0]      vector_q, vector_d;
    logic [9:0]      vec_off;
    logic            take_start;

    // Two-flop synchroniser per line plus a history flop for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= irq;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // Pending: the taken line is cleared as TAKE ends; a simultaneous new edge re-sets it
    always_comb begin
        take_clr = '0;
        if (state_q == StTake) begin
            take_clr[id_q] = 1'b1;
        end
        pending_d = (pending_q & ~take_clr) | rise;
    end

    // Control registers: ie_clr has priority over ie_set
    always_comb begin
        gie_d = gie_q;
        if (ie_set) begin
            gie_d = 1'b1;
        end
        if (ie_clr) begin
            gie_d = 1'b0;
        end
        mask_d = mask_we ? mask_in : mask_q;
    end

    // Priority pick: lowest eligible index wins
    always_comb begin
        eligible = pending_q & mask_q;
        win_id   = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_id = IdW'(i);
            end
        end
    end

    // stack_full only gates the decision in IDLE
    assign take_start = (state_q == StIdle) & gie_q & (|eligible) & ~stack_full;

    // Winner id and its vector are captured on entry to TAKE and held until the next take
    always_comb begin
        vec_off  = 10'(32'(win_id) * VEC_STRIDE);
        id_d     = take_start ? win_id : id_q;
        vector_d = take_start ? (VEC_BASE + vec_off) : vector_q;
    end

    // Sticky error for a reti that has no handler to return from
    always_comb begin
        reti_err_d = reti_err_q;
        if (reti && ((state_q == StIdle) || (state_q == StTake))) begin
            reti_err_d = 1'b1;
        end
    end

    // Datapath and control register state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q  <= '0;
            mask_q     <= '0;
            gie_q      <= 1'b0;
            reti_err_q <= 1'b0;
            id_q       <= '0;
            vector_q   <= '0;
        end else begin
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            gie_q      <= gie_d;
            reti_err_q <= reti_err_d;
            id_q       <= id_d;
            vector_q   <= vector_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one take, one service, one return cycle; reti in RETURN is ignored
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (take_start) begin
                    state_d = StTake;
                end
            end
            StTake: begin
                state_d = StService;
            end
            StService: begin
                if (reti) begin
                    state_d = StReturn;
                end
            end
            StReturn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: decoded purely from registered state, so push and pop are exclusive
    always_comb begin
        push        = 1'b0;
        pop         = 1'b0;
        stack_int   = 1'b0;
        pc_redirect = 1'b0;
        in_service  = 1'b0;
        case (state_q)
            StTake: begin
                push        = 1'b1;
                stack_int   = 1'b1;
                pc_redirect = 1'b1;
            end
            StService: begin
                in_service = 1'b1;
            end
            StReturn: begin
                pop        = 1'b1;
                stack_int  = 1'b1;
                in_service = 1'b1;
            end
            default: begin
            end
        endcase
        vector   = vector_q;
        pending  = pending_q;
        reti_err = reti_err_q;
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_irq_ctrl;

    localparam int unsigned N      = 4;
    localparam int unsigned VBASE  = 'h3C0;
    localparam int unsigned VSTRD  = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] irq;
    logic         ie_set, ie_clr, mask_we, reti, stack_full;
    logic [N-1:0] mask_in;
    logic         push, pop, stack_int, pc_redirect, in_service, reti_err;
    logic [9:0]   vector;
    logic [N-1:0] pending;

    irq_ctrl #(
        .NIRQ      (N),
        .VEC_BASE  (10'h3C0),
        .VEC_STRIDE(VSTRD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .ie_set     (ie_set),
        .ie_clr     (ie_clr),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .reti       (reti),
        .stack_full (stack_full),
        .push       (push),
        .pop        (pop),
        .stack_int  (stack_int),
        .pc_redirect(pc_redirect),
        .vector     (vector),
        .in_service (in_service),
        .pending    (pending),
        .reti_err   (reti_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model: irq samples seen at each edge, newest first
    logic [N-1:0] smp[$];
    logic [N-1:0] m_pend, m_mask;
    logic         m_gie, m_err;
    logic         m_take, m_serv, m_ret;
    int           m_line;
    logic [9:0]   m_vec;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        smp = {4'b0, 4'b0, 4'b0, 4'b0};
        m_pend = '0;
        m_mask = '0;
        m_gie  = 1'b0;
        m_err  = 1'b0;
        m_take = 1'b0;
        m_serv = 1'b0;
        m_ret  = 1'b0;
        m_line = 0;
        m_vec  = '0;
    endtask

    // One rising edge of the model, using the inputs that were stable before the edge
    task automatic model_step();
        logic [N-1:0] rise, elig, np;
        logic         idle;
        int           w;
        smp.push_front(irq);
        void'(smp.pop_back());
        // A line pends when it was high two edges ago and low three edges ago
        rise = smp[2] & ~smp[3];
        elig = m_pend & m_mask;
        idle = !m_take && !m_serv && !m_ret;
        if (reti && (idle || m_take)) m_err = 1'b1;
        np = m_pend;
        if (m_take) begin
            np[m_line] = 1'b0;
            m_take = 1'b0;
            m_serv = 1'b1;
        end else if (m_serv) begin
            if (reti) begin
                m_serv = 1'b0;
                m_ret  = 1'b1;
            end
        end else if (m_ret) begin
            m_ret = 1'b0;
        end else if (m_gie && (elig != 0) && !stack_full) begin
            w = 0;
            for (int i = 0; i < N; i++) begin
                if (elig[i]) begin
                    w = i;
                    break;
                end
            end
            m_line = w;
            m_take = 1'b1;
            m_vec  = 10'((VBASE + w * VSTRD) % 1024);
        end
        m_pend = np | rise;
        if (ie_clr) m_gie = 1'b0;
        else if (ie_set) m_gie = 1'b1;
        if (mask_we) m_mask = mask_in;
    endtask

    task automatic compare_all();
        logic [19:0] act, exp;
        act = {push, pop, stack_int, pc_redirect, in_service, reti_err, vector, pending};
        exp = {m_take, m_ret, m_take | m_ret, m_take, m_serv | m_ret, m_err, m_vec, m_pend};
        check($sformatf("cycle %0d outputs {push,pop,sint,redir,insvc,err,vec,pend}", cyc),
              64'(act), 64'(exp));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        compare_all();
    endtask

    task automatic enable_all();
        ie_set = 1'b1; mask_we = 1'b1; mask_in = 4'hF;
        cycle();
        ie_set = 1'b0; mask_we = 1'b0;
    endtask

    task automatic do_return();
        reti = 1'b1;
        cycle();
        reti = 1'b0;
        cycle();
    endtask

    function automatic logic [19:0] all_outs();
        return {push, pop, stack_int, pc_redirect, in_service, reti_err, vector, pending};
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        irq = '0; ie_set = 0; ie_clr = 0; mask_we = 0; mask_in = '0; reti = 0; stack_full = 0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset outputs", 64'(all_outs()), 64'(0));
        reset = 1'b1;

        // Single request on line 2
        enable_all();
        irq = 4'b0100; cycle();
        irq = 4'b0000; cycle(); cycle();
        check("t1 pending after 3 edges", 64'(pending), 64'(4'b0100));
        cycle();
        check("t1 take strobes", 64'({push, stack_int, pc_redirect}), 64'(3'b111));
        check("t1 vector", 64'(vector), 64'(10'h3C8));
        cycle();
        check("t1 service", 64'({pending, in_service}), 64'({4'b0000, 1'b1}));
        reti = 1'b1; cycle(); reti = 1'b0;
        check("t1 return", 64'({pop, stack_int, push}), 64'(3'b110));
        cycle();
        check("t1 back idle", 64'(in_service), 64'(0));

        // Lines 1 and 3 together: lowest index first
        irq = 4'b1010; cycle(); cycle(); cycle();
        check("t2 pending", 64'(pending), 64'(4'b1010));
        cycle();
        check("t2 first vector", 64'({push, vector}), 64'({1'b1, 10'h3C4}));
        cycle();
        check("t2 line3 still pending", 64'({pending, in_service}), 64'({4'b1000, 1'b1}));
        reti = 1'b1; cycle(); reti = 1'b0;
        check("t2 return pop", 64'({pop, stack_int}), 64'(2'b11));
        cycle();
        check("t2 idle between", 64'(push), 64'(0));
        cycle();
        check("t2 second vector", 64'({push, vector}), 64'({1'b1, 10'h3CC}));
        cycle();
        do_return();
        irq = 4'b0000;

        // gie off: request pends, no take until enabled
        ie_clr = 1'b1; cycle(); ie_clr = 1'b0;
        irq = 4'b0001; cycle(); irq = 4'b0000; cycle(); cycle();
        repeat (3) cycle();
        check("t3 gie off held", 64'({push, pending}), 64'({1'b0, 4'b0001}));
        ie_set = 1'b1; cycle(); ie_set = 1'b0;
        cycle();
        check("t3 gie on take", 64'({push, vector}), 64'({1'b1, 10'h3C0}));
        cycle();
        do_return();

        // mask[0] off: request pends, no take until unmasked
        mask_we = 1'b1; mask_in = 4'b1110; cycle(); mask_we = 1'b0;
        irq = 4'b0001; cycle(); irq = 4'b0000; cycle(); cycle();
        repeat (2) cycle();
        check("t3 masked held", 64'({push, pending}), 64'({1'b0, 4'b0001}));
        mask_we = 1'b1; mask_in = 4'b1111; cycle(); mask_we = 1'b0;
        cycle();
        check("t3 unmask take", 64'(push), 64'(1));
        cycle();
        do_return();

        // stack_full blocks takes
        stack_full = 1'b1;
        irq = 4'b1000; cycle(); irq = 4'b0000; cycle(); cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("t4 blocked %0d", i), 64'(push), 64'(0));
        end
        stack_full = 1'b0;
        cycle();
        check("t4 take after drop", 64'({push, vector}), 64'({1'b1, 10'h3CC}));
        cycle();
        do_return();

        // reti in IDLE sets the sticky error without a pop
        reti = 1'b1; cycle(); reti = 1'b0;
        check("t5 reti_err", 64'({reti_err, pop}), 64'(2'b10));
        irq = 4'b0010; cycle(); irq = 4'b0000; cycle(); cycle(); cycle(); cycle();
        check("t5 in service", 64'(in_service), 64'(1));
        reset = 1'b0;
        #1;
        check("t5 async reset outputs", 64'(all_outs()), 64'(0));
        model_reset();
        #2 reset = 1'b1;
        enable_all();

        // New edge on the taken line during TAKE keeps it pending
        irq = 4'b0100; cycle();
        irq = 4'b0000; cycle();
        irq = 4'b0100; cycle();
        irq = 4'b0000; cycle();
        check("t6 take", 64'(push), 64'(1));
        cycle();
        check("t6 re-pend", 64'({pending, in_service}), 64'({4'b0100, 1'b1}));
        do_return();
        cycle();
        cycle();
        do_return();

        // Randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) irq[b] = ~irq[b];
            end
            ie_set     = ($urandom_range(0, 19) == 0);
            ie_clr     = ($urandom_range(0, 39) == 0);
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_in    = N'($urandom);
            reti       = ($urandom_range(0, 5) == 0);
            stack_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 499) == 0) begin
                reset = 1'b0;
                #2;
                model_reset();
                check("random async reset", 64'(all_outs()), 64'(0));
                #1 reset = 1'b1;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
